axis_slave_rx: RTL and testbench

AXI4-Stream slave receiver for the user-project AXI-Lite/AXIS bridge; the consuming stage that accepts beats produced by the axis master of the neighbouring subsystem. Each accepted beat (tdata, tuser, tlast) is buffered in a small synchronous FIFO and presented to the backend on a valid/ready interface. Backpressure goes to the stream source through axis_tready whenever the FIFO is full.

---
 rtl/fsic_axis_pkg.sv | 10 +
 rtl/fsic_sync_fifo.sv | 48 ++++
 rtl/axis_slave_rx.sv | 59 +++++
 tb/tb_axis_slave_rx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fsic_axis_pkg.sv
// fsic_axis_pkg: shared AXI4-Stream widths and the buffered beat layout.
package fsic_axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_USER_W = 2;
  typedef struct packed {
    logic [AXIS_USER_W-1:0] tuser;
    logic                   tlast;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_beat_t;
endpackage

// File: rtl/fsic_sync_fifo.sv
// fsic_sync_fifo: synchronous FIFO of DEPTH entries of type T (DEPTH a power of two, >= 2).
// Ports: axi_aclk/axi_aresetn (async active-low), i_push/i_din write side,
// i_pop/o_dout read side (o_dout = head entry), o_full/o_empty/o_level status.
// Push is ignored when full and pop is ignored when empty; full/empty decode only from r_count.
module fsic_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic                     i_push,
  input  T                         i_din,
  input  logic                     i_pop,
  output T                         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_count == LW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_level = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
    end
endmodule

// File: rtl/axis_slave_rx.sv
// axis_slave_rx: AXI4-Stream slave that buffers beats in a FIFO and presents them on a valid/ready backend.
// Ports: axi_aclk/axi_aresetn (async active-low); axis_t* stream slave input with axis_tready
// backpressure (tstrb/tkeep ignored); bk_data/bk_user/bk_last/bk_valid/bk_ready backend;
// fifo_level occupancy; rx_beat_cnt accepted-beat counter present only when FSIC_AXIS_RX_CNT_EN is defined.
module axis_slave_rx
  import fsic_axis_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic                    axis_tvalid,
  input  logic [AXIS_DATA_W-1:0]  axis_tdata,
  input  logic [3:0]              axis_tstrb,
  input  logic [3:0]              axis_tkeep,
  input  logic                    axis_tlast,
  input  logic [AXIS_USER_W-1:0]  axis_tuser,
  output logic                    axis_tready,
  output logic [AXIS_DATA_W-1:0]  bk_data,
  output logic [AXIS_USER_W-1:0]  bk_user,
  output logic                    bk_last,
  output logic                    bk_valid,
  input  logic                    bk_ready,
`ifdef FSIC_AXIS_RX_CNT_EN
  output logic [15:0]             rx_beat_cnt,
`endif
  output logic [$clog2(DEPTH):0]  fifo_level
);
  axis_beat_t w_in;
  axis_beat_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_unused;
  assign w_in     = '{tuser: axis_tuser, tlast: axis_tlast, tdata: axis_tdata};
  assign w_unused = ^{axis_tstrb, axis_tkeep};
  assign axis_tready = ~w_full;
  assign bk_valid    = ~w_empty;
  assign bk_data     = w_head.tdata;
  assign bk_user     = w_head.tuser;
  assign bk_last     = w_head.tlast;
  fsic_sync_fifo #(.DEPTH(DEPTH), .T(axis_beat_t)) u_fifo (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .i_push      (axis_tvalid),
    .i_din       (w_in),
    .i_pop       (bk_ready),
    .o_dout      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level)
  );
`ifdef FSIC_AXIS_RX_CNT_EN
  logic [15:0] r_beat_cnt;
  assign rx_beat_cnt = r_beat_cnt;
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) r_beat_cnt <= '0;
    else if (axis_tvalid & axis_tready) r_beat_cnt <= r_beat_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_axis_slave_rx.sv
// tb_axis_slave_rx: directed self-checking bench for axis_slave_rx.
module tb_axis_slave_rx;
  logic        axi_aclk = 0;
  logic        axi_aresetn = 0;
  logic        axis_tvalid = 0;
  logic [31:0] axis_tdata = 0;
  logic [3:0]  axis_tstrb = 0;
  logic [3:0]  axis_tkeep = 0;
  logic        axis_tlast = 0;
  logic [1:0]  axis_tuser = 0;
  logic        axis_tready;
  logic [31:0] bk_data;
  logic [1:0]  bk_user;
  logic        bk_last;
  logic        bk_valid;
  logic        bk_ready = 0;
  logic [2:0]  fifo_level;
`ifdef FSIC_AXIS_RX_CNT_EN
  logic [15:0] rx_beat_cnt;
`endif
  int errors = 0;
  int checks = 0;
  axis_slave_rx #(.DEPTH(4)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .axis_tvalid (axis_tvalid),
    .axis_tdata  (axis_tdata),
    .axis_tstrb  (axis_tstrb),
    .axis_tkeep  (axis_tkeep),
    .axis_tlast  (axis_tlast),
    .axis_tuser  (axis_tuser),
    .axis_tready (axis_tready),
    .bk_data     (bk_data),
    .bk_user     (bk_user),
    .bk_last     (bk_last),
    .bk_valid    (bk_valid),
    .bk_ready    (bk_ready),
`ifdef FSIC_AXIS_RX_CNT_EN
    .rx_beat_cnt (rx_beat_cnt),
`endif
    .fifo_level  (fifo_level)
  );
  always #5 axi_aclk = ~axi_aclk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask
  initial begin
    int exp_out;
    int max_lvl;
    repeat (2) step();
    chk("rst_tready", axis_tready, 1);
    chk("rst_bk_valid", bk_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_bk_data", bk_data, 0);
    @(negedge axi_aclk);
    axi_aresetn = 1;
    step();
    axis_tvalid = 1; axis_tdata = 32'hA5A5_0001; axis_tuser = 2'b10; axis_tlast = 1;
    step();
    axis_tvalid = 0; axis_tlast = 0; axis_tuser = 0;
    chk("one_valid", bk_valid, 1);
    chk("one_data", bk_data, 32'hA5A5_0001);
    chk("one_user", bk_user, 2'b10);
    chk("one_last", bk_last, 1);
    chk("one_level", fifo_level, 1);
    bk_ready = 1;
    step();
    bk_ready = 0;
    chk("one_drained", bk_valid, 0);
    for (int i = 0; i < 4; i++) begin
      axis_tvalid = 1; axis_tdata = 32'h10 + i;
      step();
    end
    chk("full_level", fifo_level, 4);
    chk("full_tready", axis_tready, 0);
    axis_tdata = 32'h14;
    repeat (2) step();
    chk("full_hold_level", fifo_level, 4);
    chk("full_hold_head", bk_data, 32'h10);
    bk_ready = 1;
    step();
    bk_ready = 0;
    chk("fullpop_level", fifo_level, 3);
    chk("fullpop_tready", axis_tready, 1);
    chk("fullpop_head", bk_data, 32'h11);
    step();
    axis_tvalid = 0;
    chk("refill_level", fifo_level, 4);
    bk_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("order", bk_data, 32'h11 + i);
      step();
    end
    bk_ready = 0;
    chk("drained_valid", bk_valid, 0);
    exp_out = 0;
    max_lvl = 0;
    bk_ready = 1;
    for (int i = 0; i <= 256; i++) begin
      axis_tvalid = (i < 256);
      axis_tdata = i;
      if (bk_valid) begin
        chk("stream", bk_data, exp_out);
        exp_out++;
      end
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      step();
    end
    bk_ready = 0;
    axis_tvalid = 0;
    chk("stream_count", exp_out, 256);
    chk("stream_maxlvl", max_lvl, 1);
    chk("stream_empty", bk_valid, 0);
    for (int i = 0; i < 3; i++) begin
      axis_tvalid = 1; axis_tdata = 32'h50 + i;
      step();
    end
    chk("pre_rst_level", fifo_level, 3);
    #2 axi_aresetn = 0;
    #1;
    chk("mid_rst_valid", bk_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_tready", axis_tready, 1);
    axis_tvalid = 0;
    @(negedge axi_aclk);
    axi_aresetn = 1;
    step();
    chk("post_rst_valid", bk_valid, 0);
    chk("post_rst_data", bk_data, 0);
    axis_tvalid = 1; axis_tdata = 32'h77;
    step();
    axis_tvalid = 0;
    chk("post_rst_head", bk_data, 32'h77);
    chk("post_rst_level", fifo_level, 1);
`ifdef FSIC_AXIS_RX_CNT_EN
    @(negedge axi_aclk);
    axi_aresetn = 0;
    #1;
    chk("cnt_rst", rx_beat_cnt, 0);
    @(negedge axi_aclk);
    axi_aresetn = 1;
    step();
    axis_tvalid = 1; bk_ready = 1;
    repeat (65538) step();
    axis_tvalid = 0;
    step();
    bk_ready = 0;
    chk("cnt_wrap", rx_beat_cnt, 2);
    chk("cnt_wrap_level", fifo_level, 0);
    axis_tvalid = 1;
    repeat (2) step();
    axis_tvalid = 0;
    chk("cnt_push2", rx_beat_cnt, 4);
    bk_ready = 1;
    repeat (2) step();
    bk_ready = 0;
    chk("cnt_pop_only", rx_beat_cnt, 4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
